// File: rtl/score_display_if.sv
// -----------------------------------------------------------------------------
// score_display_if
// Bundles the score_display data path: the four BCD score digits and the
// game_over level coming in, and the multiplexed seven-segment drive going out.
//
// Signals:
//   score_digit3..0 : BCD thousands..units digits (from the score counter)
//   game_over       : level, display blinks indefinitely while high
//   ssd_an          : active-low anodes, bit0 = rightmost (units) digit
//   ssd_seg         : active-low segments {dp,g,f,e,d,c,b,a}
//
// Modports:
//   master : score source / bench side (drives digits, observes display)
//   slave  : score_display side (consumes digits, drives display)
//
// Handshake: none. Digits and game_over are plain levels sampled once per scan
// frame; the display outputs are continuously valid registered levels.
// -----------------------------------------------------------------------------
interface score_display_if;
   logic [3:0] score_digit3;
   logic [3:0] score_digit2;
   logic [3:0] score_digit1;
   logic [3:0] score_digit0;
   logic       game_over;
   logic [3:0] ssd_an;
   logic [7:0] ssd_seg;

   modport master (
      output score_digit3, score_digit2, score_digit1, score_digit0, game_over,
      input  ssd_an, ssd_seg
   );

   modport slave (
      input  score_digit3, score_digit2, score_digit1, score_digit0, game_over,
      output ssd_an, ssd_seg
   );
endinterface

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
// Time-multiplexes four BCD score digits onto a 4-digit common-anode seven
// segment display with leading-zero blanking. The digits are snapshotted once
// per scan frame so a multi-digit update never tears. A change of the shown
// score flashes the display for FLASH_FRAMES frames; game_over blinks it for
// as long as it stays high.
//
// Ports:
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   bus     : score_display_if.slave (digits + game_over in, ssd_an/ssd_seg out)
//   state_o : current display state (0 = SHOW, 1 = FLASH, 2 = OVER)
// -----------------------------------------------------------------------------
module score_display #(
   parameter int SCAN_DIV     = 100000,
   parameter int FLASH_FRAMES = 64,
   parameter int BLINK_HALF   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   score_display_if.slave        bus,
   output logic [1:0]            state_o
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = $clog2(FLASH_FRAMES + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);

   localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
   localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      ST_SHOW  = 2'd0,
      ST_FLASH = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   snap_q;
   logic [FW-1:0] flash_cnt_q;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   state_t        state_q;
   logic [3:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;

   logic [15:0]   digits_in;
   logic          tick;
   logic          frame_end;
   logic          changed;
   logic          gov;

   assign digits_in = {bus.score_digit3, bus.score_digit2,
                       bus.score_digit1, bus.score_digit0};
   assign gov       = bus.game_over;
   assign tick      = (presc_q == PRESC_MAX);
   assign frame_end = tick && (idx_q == 2'd3);
   // Compared against the snapshot about to be replaced on this frame_end.
   assign changed   = (digits_in != snap_q);

   assign presc_d = tick ? '0 : presc_q + PW'(1);
   assign idx_d   = tick ? idx_q + 2'd1 : idx_q;

   // One blink step, shared by FLASH and OVER.
   always_comb begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_on_d  = blink_on_q;
      if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end
   end

   // Scan timing and per-frame snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
         snap_q  <= 16'h0000;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         if (frame_end) snap_q <= digits_in;
      end
   end

   // Display state machine; advances only at frame boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SHOW;
         flash_cnt_q <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (frame_end) begin
         case (state_q)
            ST_SHOW: begin
               blink_on_q <= 1'b1;
               if (gov) begin
                  state_q     <= ST_OVER;
                  blink_cnt_q <= '0;
               end else if (changed) begin
                  state_q     <= ST_FLASH;
                  flash_cnt_q <= FLASH_LOAD;
                  blink_cnt_q <= '0;
               end
            end
            ST_FLASH: begin
               if (gov) begin
                  state_q     <= ST_OVER;
                  blink_cnt_q <= blink_cnt_d;
                  blink_on_q  <= blink_on_d;
               end else if (changed) begin
                  // Restart the timeout but keep the blink phase running.
                  flash_cnt_q <= FLASH_LOAD;
                  blink_cnt_q <= blink_cnt_d;
                  blink_on_q  <= blink_on_d;
               end else if (flash_cnt_q <= FW'(1)) begin
                  state_q     <= ST_SHOW;
                  flash_cnt_q <= '0;
                  blink_cnt_q <= '0;
                  blink_on_q  <= 1'b1;
               end else begin
                  flash_cnt_q <= flash_cnt_q - FW'(1);
                  blink_cnt_q <= blink_cnt_d;
                  blink_on_q  <= blink_on_d;
               end
            end
            ST_OVER: begin
               if (!gov) begin
                  blink_cnt_q <= '0;
                  blink_on_q  <= 1'b1;
                  if (changed) begin
                     state_q     <= ST_FLASH;
                     flash_cnt_q <= FLASH_LOAD;
                  end else begin
                     state_q     <= ST_SHOW;
                     flash_cnt_q <= '0;
                  end
               end else begin
                  blink_cnt_q <= blink_cnt_d;
                  blink_on_q  <= blink_on_d;
               end
            end
            default: begin
               state_q     <= ST_SHOW;
               flash_cnt_q <= '0;
               blink_cnt_q <= '0;
               blink_on_q  <= 1'b1;
            end
         endcase
      end
   end

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hBF;  // non-BCD shows a dash
      endcase
      return s;
   endfunction

   // Next display drive for the slot selected by idx_q. A dash digit is
   // non-zero, so it never counts as a leading zero.
   always_comb begin
      logic [3:0] cur;
      logic       blank;
      logic [3:0] an_sel;
      logic       z3, z2, z1;
      z3     = (snap_q[15:12] == 4'd0);
      z2     = (snap_q[11:8]  == 4'd0);
      z1     = (snap_q[7:4]   == 4'd0);
      cur    = snap_q[3:0];
      blank  = 1'b0;
      an_sel = 4'b1110;
      case (idx_q)
         2'd0: begin cur = snap_q[3:0];   blank = 1'b0;         an_sel = 4'b1110; end
         2'd1: begin cur = snap_q[7:4];   blank = z3 && z2 && z1; an_sel = 4'b1101; end
         2'd2: begin cur = snap_q[11:8];  blank = z3 && z2;     an_sel = 4'b1011; end
         default: begin cur = snap_q[15:12]; blank = z3;        an_sel = 4'b0111; end
      endcase
      an_d  = 4'b1111;
      seg_d = 8'hFF;
      if (blink_on_q && !blank) begin
         an_d  = an_sel;
         seg_d = seg_decode(cur);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= 4'b1111;
         seg_q <= 8'hFF;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign bus.ssd_an  = an_q;
   assign bus.ssd_seg = seg_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

   localparam int SCAN_DIV     = 4;
   localparam int FLASH_FRAMES = 4;
   localparam int BLINK_HALF   = 1;
   localparam int FRAME        = 4 * SCAN_DIV;

   // Expected {ssd_an, ssd_seg} per slot.
   localparam logic [11:0] BL = 12'hFFF;

   localparam logic [1:0] S_SHOW  = 2'd0;
   localparam logic [1:0] S_FLASH = 2'd1;
   localparam logic [1:0] S_OVER  = 2'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_o;

   score_display_if bus();

   score_display #(
      .SCAN_DIV    (SCAN_DIV),
      .FLASH_FRAMES(FLASH_FRAMES),
      .BLINK_HALF  (BLINK_HALF)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Clock edges since reset release; slot/frame position is derived from it.
   int ecnt;
   always @(posedge clk or posedge rst) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   // ---------------- scoreboard ----------------
   logic [11:0] exp_q[$];
   int          checks = 0;
   int          fails  = 0;
   logic [11:0] mon_exp;
   logic [11:0] mon_got;

   // Samples the middle of every slot and checks it against the next
   // expected entry, when one is pending.
   always @(negedge clk) begin
      if (!rst && (ecnt % SCAN_DIV == 3) && exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {bus.ssd_an, bus.ssd_seg};
         checks++;
         if (mon_got !== mon_exp) begin
            fails++;
            $display("FAIL slot%0d edge %0d: got an=%b seg=%h, expected an=%b seg=%h",
                     ((ecnt - 1) / SCAN_DIV) % 4, ecnt, mon_got[11:8], mon_got[7:0],
                     mon_exp[11:8], mon_exp[7:0]);
         end
         checks++;
         if ($countones(~bus.ssd_an) > 1) begin
            fails++;
            $display("FAIL anode_onehot edge %0d: got an=%b, expected at most one low",
                     ecnt, bus.ssd_an);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_val(input string name, input logic [11:0] got,
                            input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Advance to just after the first edge of the next frame.
   task automatic wait_frame_start();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while ((ecnt % FRAME) != 1 && n < 2 * FRAME + 4);
      checks++;
      if ((ecnt % FRAME) != 1) begin
         fails++;
         $display("FAIL frame_align: got edge %0d, expected a frame start", ecnt);
      end
   endtask

   // Queue the four slot values expected during the next frame.
   task automatic expect_frame(input logic [11:0] s0, input logic [11:0] s1,
                               input logic [11:0] s2, input logic [11:0] s3);
      wait_frame_start();
      exp_q.push_back(s0);
      exp_q.push_back(s1);
      exp_q.push_back(s2);
      exp_q.push_back(s3);
   endtask

   // Change the inputs a few cycles into the current frame.
   task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
      repeat (6) @(negedge clk);
      bus.score_digit3 = d3;
      bus.score_digit2 = d2;
      bus.score_digit1 = d1;
      bus.score_digit0 = d0;
   endtask

   task automatic set_go(input logic g);
      bus.game_over = g;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1;
      bus.score_digit3 = 4'd0;
      bus.score_digit2 = 4'd0;
      bus.score_digit1 = 4'd0;
      bus.score_digit0 = 4'd0;
      bus.game_over    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outputs", {bus.ssd_an, bus.ssd_seg}, BL);
      check_val("reset_state", {10'd0, state_o}, {10'd0, S_SHOW});
      @(negedge clk);
      rst = 1'b0;

      // Zero score: only the units digit lights.
      expect_frame(12'hEC0, BL, BL, BL);
      set_digits(4'd0, 4'd1, 4'd2, 4'd0);                  // 120
      expect_frame(12'hEC0, 12'hDA4, 12'hBF9, BL);          // flash on
      check_val("state_flash", {10'd0, state_o}, {10'd0, S_FLASH});
      expect_frame(BL, BL, BL, BL);                         // flash off
      expect_frame(12'hEC0, 12'hDA4, 12'hBF9, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hEC0, 12'hDA4, 12'hBF9, BL);          // steady
      expect_frame(12'hEC0, 12'hDA4, 12'hBF9, BL);
      check_val("state_show", {10'd0, state_o}, {10'd0, S_SHOW});

      // Mid-frame change to 40: old value held for the rest of the frame.
      set_digits(4'd0, 4'd0, 4'd4, 4'd0);
      expect_frame(12'hEC0, 12'hD99, BL, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hEC0, 12'hD99, BL, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hEC0, 12'hD99, BL, BL);
      expect_frame(12'hEC0, 12'hD99, BL, BL);

      // Non-BCD tens digit shows a dash.
      set_digits(4'd0, 4'd0, 4'hC, 4'd0);
      expect_frame(12'hEC0, 12'hDBF, BL, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hEC0, 12'hDBF, BL, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hEC0, 12'hDBF, BL, BL);

      // game_over together with a score change: OVER wins, blinks past timeout.
      set_digits(4'd0, 4'd0, 4'd0, 4'd5);
      set_go(1'b1);
      expect_frame(12'hE92, BL, BL, BL);
      check_val("state_over", {10'd0, state_o}, {10'd0, S_OVER});
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hE92, BL, BL, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hE92, BL, BL, BL);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hE92, BL, BL, BL);
      set_go(1'b0);
      expect_frame(12'hE92, BL, BL, BL);                    // back to steady
      expect_frame(12'hE92, BL, BL, BL);

      // game_over falls on the same frame as a change: goes to FLASH.
      set_go(1'b1);
      expect_frame(12'hE92, BL, BL, BL);
      expect_frame(BL, BL, BL, BL);
      set_digits(4'd0, 4'd0, 4'd0, 4'd7);
      set_go(1'b0);
      expect_frame(12'hEF8, BL, BL, BL);
      expect_frame(BL, BL, BL, BL);

      // Reset in the middle of a lit flash slot.
      wait_frame_start();
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_reset_outputs", {bus.ssd_an, bus.ssd_seg}, BL);
      check_val("async_reset_state", {10'd0, state_o}, {10'd0, S_SHOW});
      bus.score_digit0 = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Resumes at idx 0, showing 0, no flash.
      expect_frame(12'hEC0, BL, BL, BL);
      expect_frame(12'hEC0, BL, BL, BL);
      check_val("post_reset_state", {10'd0, state_o}, {10'd0, S_SHOW});

      // Remaining decode values, all four digits lit.
      set_digits(4'd3, 4'd6, 4'd8, 4'd9);
      expect_frame(12'hE90, 12'hD80, 12'hB82, 12'h7B0);
      expect_frame(BL, BL, BL, BL);
      // Change during flash restarts the timeout; inner zeros are not blanked.
      set_digits(4'd1, 4'd0, 4'd0, 4'd5);
      expect_frame(12'hE92, 12'hDC0, 12'hBC0, 12'h7F9);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hE92, 12'hDC0, 12'hBC0, 12'h7F9);
      expect_frame(BL, BL, BL, BL);
      expect_frame(12'hE92, 12'hDC0, 12'hBC0, 12'h7F9);
      expect_frame(12'hE92, 12'hDC0, 12'hBC0, 12'h7F9);

      // Drain the scoreboard.
      n = 0;
      while (exp_q.size() != 0 && n < 4 * FRAME) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
